// File: rtl/nn_pkg.sv
// Shared fixed-point helpers for the neuron datapath: saturation bounds and a
// saturating add in product format.
package nn_pkg;

  localparam int DATA_W = 16;
  localparam int PROD_W = 2 * DATA_W;

  // Bounds are returned 64 bits wide; callers keep the low w bits.
  function automatic logic [63:0] SAT_MAX(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] SAT_MIN(input int w);
    return 64'd1 << (w - 1);
  endfunction

  function automatic logic [PROD_W-1:0] sat_add(input logic [PROD_W-1:0] a,
                                                input logic [PROD_W-1:0] b);
    logic [PROD_W-1:0] raw;
    logic [63:0] mx;
    logic [63:0] mn;
    raw = a + b;
    mx  = SAT_MAX(PROD_W);
    mn  = SAT_MIN(PROD_W);
    if (!a[PROD_W-1] && !b[PROD_W-1] && raw[PROD_W-1]) return mx[PROD_W-1:0];
    if (a[PROD_W-1] && b[PROD_W-1] && !raw[PROD_W-1]) return mn[PROD_W-1:0];
    return raw;
  endfunction

endpackage

// File: rtl/neuron_mac_sat_adder.sv
// Combinational W-bit signed add that clamps to the representable range
// instead of wrapping.
module sat_adder
  import nn_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  localparam logic [63:0] MAX64 = SAT_MAX(W);
  localparam logic [63:0] MIN64 = SAT_MIN(W);
  localparam logic [W-1:0] MAX_V = MAX64[W-1:0];
  localparam logic [W-1:0] MIN_V = MIN64[W-1:0];

  logic [W-1:0] raw;

  assign raw = a + b;

  always_comb begin
    y = raw;
    if (!a[W-1] && !b[W-1] && raw[W-1]) y = MAX_V;
    else if (a[W-1] && b[W-1] && !raw[W-1]) y = MIN_V;
  end

endmodule

// File: rtl/neuron_mac.sv
// Streaming multiply-accumulate front end of one neuron: weight fetch,
// saturating accumulate, bias add, one double-width sum per vector.
module neuron_mac
  import nn_pkg::*;
#(
  parameter int dataWidth = 16,
  parameter int numInputs = 784,
  parameter int addrWidth = $clog2(numInputs)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [dataWidth-1:0]     in_data,
  output logic [addrWidth-1:0]     w_addr,
  input  logic [dataWidth-1:0]     w_data,
  input  logic [2*dataWidth-1:0]   bias,
  output logic [2*dataWidth-1:0]   sum,
  output logic                     sum_valid,
  output logic                     busy
);

  localparam int PW = 2 * dataWidth;
  localparam logic [addrWidth-1:0] LAST_IDX = addrWidth'(numInputs - 1);

  // Handshake: valid-only, no ready. Every cycle with in_valid high transfers
  // in_data; sum_valid is a one-cycle pulse with no way to stall it.
  logic [addrWidth-1:0] idx;
  logic                 in_last;
  logic                 x_valid, x_last;
  logic [dataWidth-1:0] x_d;
  logic                 mul_valid, mul_last;
  logic [PW-1:0]        p, acc, acc_sum, bias_sum;
  logic [PW-1:0]        x_ext, w_ext;
  logic                 last_pend;

  assign in_last = (idx == LAST_IDX);
  assign w_addr  = idx;
  assign x_ext   = {{dataWidth{x_d[dataWidth-1]}}, x_d};
  assign w_ext   = {{dataWidth{w_data[dataWidth-1]}}, w_data};
  assign busy    = (idx != '0) | x_valid | mul_valid | last_pend;

  sat_adder #(.W(PW)) u_acc_add  (.a(acc), .b(p),    .y(acc_sum));
  sat_adder #(.W(PW)) u_bias_add (.a(acc), .b(bias), .y(bias_sum));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      x_valid   <= 1'b0;
      x_last    <= 1'b0;
      x_d       <= '0;
      mul_valid <= 1'b0;
      mul_last  <= 1'b0;
      p         <= '0;
      acc       <= '0;
      last_pend <= 1'b0;
      sum       <= '0;
      sum_valid <= 1'b0;
    end else begin
      if (in_valid) idx <= in_last ? '0 : idx + addrWidth'(1);

      x_valid <= in_valid;
      if (in_valid) begin
        x_d    <= in_data;
        x_last <= in_last;
      end

      // The memory returns w_data one cycle after w_addr, aligned with x_d.
      mul_valid <= x_valid;
      if (x_valid) begin
        p        <= x_ext * w_ext;
        mul_last <= x_last;
      end

      // Final bias add overlaps the first product of the next vector, so the
      // accumulator restarts from that product rather than from zero.
      if (last_pend) begin
        sum       <= bias_sum;
        sum_valid <= 1'b1;
        acc       <= mul_valid ? p : '0;
        last_pend <= 1'b0;
      end else begin
        sum_valid <= 1'b0;
        if (mul_valid) begin
          acc       <= acc_sum;
          last_pend <= mul_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// Self-checking bench for neuron_mac with a 1-cycle-latency weight memory and
// an arithmetic reference model of the saturating dot product.
module tb_neuron_mac;

  localparam int DW = 16;
  localparam int NI = 4;
  localparam int AW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic [DW-1:0]   in_data = '0;
  logic [DW-1:0]   w_data = '0;
  logic [AW-1:0]   w_addr;
  logic [2*DW-1:0] bias = '0;
  logic [2*DW-1:0] sum;
  logic            sum_valid;
  logic            busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_cyc = 0;

  logic [DW-1:0]   wmem[NI];
  int              vx[NI];
  int              vw[NI];
  longint          bias_l;

  logic [2*DW-1:0] exp_q[$];
  int              exp_t[$];
  logic [2*DW-1:0] got_q[$];
  int              got_t[$];

  neuron_mac #(.dataWidth(DW), .numInputs(NI)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .w_addr(w_addr), .w_data(w_data), .bias(bias), .sum(sum),
    .sum_valid(sum_valid), .busy(busy)
  );

  // clock / reset block and memory model
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) w_data <= wmem[w_addr];

  always @(negedge clk) begin
    if (rst_n && sum_valid) begin
      got_q.push_back(sum);
      got_t.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // reference model: exact integer dot product clamped after every add
  function automatic longint clamp32(input longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  function automatic logic [2*DW-1:0] ref_sum();
    longint s;
    s = 0;
    for (int i = 0; i < NI; i++) s = clamp32(s + longint'(vx[i]) * longint'(vw[i]));
    s = clamp32(s + bias_l);
    return s[2*DW-1:0];
  endfunction

  // driver tasks
  task automatic load_vector();
    for (int i = 0; i < NI; i++) wmem[i] = DW'(vw[i]);
    bias = bias_l[2*DW-1:0];
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = DW'($urandom);
    end
  endtask

  task automatic send_input(input int i, input int exp_addr);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = DW'(vx[i]);
    last_cyc = cyc;
    checks++;
    if (w_addr !== AW'(exp_addr)) begin
      errors++;
      $display("FAIL w_addr input=%0d got=%0d exp=%0d", i, w_addr, exp_addr);
    end
  endtask

  task automatic send_vector(input int max_gap);
    for (int i = 0; i < NI; i++) begin
      send_input(i, i);
      if (i < NI - 1 && max_gap > 0) idle($urandom_range(0, max_gap));
    end
    exp_q.push_back(ref_sum());
    exp_t.push_back(last_cyc + 4);
  endtask

  task automatic wait_pulses();
    int budget;
    budget = 0;
    idle(1);
    while (got_q.size() < exp_q.size() && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    idle(6);
  endtask

  // tests
  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (sum !== '0) begin errors++; $display("FAIL reset_sum got=%h exp=0", sum); end
    checks++;
    if (sum_valid !== 1'b0) begin errors++; $display("FAIL reset_sum_valid got=%b exp=0", sum_valid); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++;
    if (w_addr !== '0) begin errors++; $display("FAIL reset_w_addr got=%0d exp=0", w_addr); end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic run_fixed(input string name, input int x0, input int x1, input int x2,
                           input int x3, input int w, input longint b);
    logic [2*DW-1:0] g, e;
    int gt, et;
    vx[0] = x0; vx[1] = x1; vx[2] = x2; vx[3] = x3;
    for (int i = 0; i < NI; i++) vw[i] = w;
    bias_l = b;
    load_vector();
    send_vector(0);
    wait_pulses();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_count got=%0d exp=%0d", name, got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      gt = got_t.pop_front(); et = exp_t.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL %s_sum got=%h exp=%h", name, g, e); end
      checks++;
      if (gt != et) begin errors++; $display("FAIL %s_latency got=%0d exp=%0d", name, gt, et); end
    end
    got_q.delete(); got_t.delete(); exp_q.delete(); exp_t.delete();
  endtask

  task automatic test_back_to_back();
    logic [2*DW-1:0] g, e;
    int t0, t1;
    for (int i = 0; i < NI; i++) vw[i] = 1;
    bias_l = 5;
    load_vector();
    for (int i = 0; i < NI; i++) vx[i] = 1;
    send_vector(0);
    for (int i = 0; i < NI; i++) vx[i] = 2;
    send_vector(0);
    wait_pulses();
    checks++;
    if (got_q.size() != 2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL b2b_sum got=%h exp=%h", g, e); end
    end
    if (got_t.size() == 2) begin
      t0 = got_t[0]; t1 = got_t[1];
      checks++;
      if (t1 - t0 != 4) begin errors++; $display("FAIL b2b_spacing got=%0d exp=4", t1 - t0); end
      checks++;
      if (t1 != exp_t[1]) begin errors++; $display("FAIL b2b_latency got=%0d exp=%0d", t1, exp_t[1]); end
    end
    got_q.delete(); got_t.delete(); exp_q.delete(); exp_t.delete();
  endtask

  task automatic test_gaps();
    logic [2*DW-1:0] g, e;
    int n;
    for (int i = 0; i < NI; i++) begin vx[i] = i + 1; vw[i] = 1; end
    bias_l = 0;
    load_vector();
    for (int i = 0; i < NI; i++) begin
      send_input(i, i);
      if (i < NI - 1) begin
        n = $urandom_range(0, 3);
        repeat (n) begin
          @(negedge clk);
          in_valid = 1'b0;
          checks++;
          if (busy !== 1'b1) begin errors++; $display("FAIL gaps_busy_gap got=%b exp=1", busy); end
        end
      end
    end
    exp_q.push_back(ref_sum());
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL gaps_busy_tail k=%0d got=%b exp=1", k, busy); end
    end
    @(negedge clk);
    checks++;
    if (sum_valid !== 1'b1) begin errors++; $display("FAIL gaps_pulse got=%b exp=1", sum_valid); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL gaps_busy_done got=%b exp=0", busy); end
    wait_pulses();
    checks++;
    if (got_q.size() != 1) begin errors++; $display("FAIL gaps_count got=%0d exp=1", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL gaps_sum got=%h exp=%h", g, e); end
    end
    got_q.delete(); got_t.delete(); exp_q.delete(); exp_t.delete();
  endtask

  task automatic test_reset_mid_vector();
    for (int i = 0; i < NI; i++) begin vx[i] = i + 1; vw[i] = 1; end
    bias_l = 0;
    load_vector();
    send_input(0, 0);
    send_input(1, 1);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (w_addr !== '0) begin errors++; $display("FAIL abort_w_addr got=%0d exp=0", w_addr); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    rst_n = 1'b1;
    idle(8);
    checks++;
    if (got_q.size() != 0) begin errors++; $display("FAIL abort_no_pulse got=%0d exp=0", got_q.size()); end
    got_q.delete(); got_t.delete();
    run_fixed("after_abort", 1, 2, 3, 4, 1, 0);
  endtask

  task automatic test_random();
    logic [2*DW-1:0] g, e;
    int gt, et;
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < NI; i++) begin
        vx[i] = int'($signed(DW'($urandom)));
        vw[i] = int'($signed(DW'($urandom)));
      end
      bias_l = longint'($signed(32'($urandom)));
      load_vector();
      send_vector(2);
      wait_pulses();
      checks++;
      if (got_q.size() != 1) begin errors++; $display("FAIL rand_count v=%0d got=%0d exp=1", v, got_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
        g = got_q.pop_front(); e = exp_q.pop_front();
        gt = got_t.pop_front(); et = exp_t.pop_front();
        checks++;
        if (g !== e) begin errors++; $display("FAIL rand_sum v=%0d got=%h exp=%h", v, g, e); end
        checks++;
        if (gt != et) begin errors++; $display("FAIL rand_latency v=%0d got=%0d exp=%0d", v, gt, et); end
      end
      got_q.delete(); got_t.delete(); exp_q.delete(); exp_t.delete();
    end
  endtask

  initial begin
    for (int i = 0; i < NI; i++) wmem[i] = '0;
    test_reset();
    run_fixed("basic", 1, 2, 3, 4, 1, 0);
    run_fixed("pos_sat", -32768, -32768, -32768, -32768, -32768, 0);
    run_fixed("neg_sat", -32768, -32768, -32768, -32768, 32767, -1);
    test_back_to_back();
    test_gaps();
    test_reset_mid_vector();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
